// File: rtl/button_debounce_pkg.sv
// Shared types and default constants for the push-button debouncer and its helpers.
package button_debounce_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 120_000;     // 10 ms at 12 MHz
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 12_000_000;  // 1 s at 12 MHz
  localparam int unsigned COUNT_W               = 8;

  typedef enum logic [1:0] {
    ST_RELEASED   = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_DB_RELEASE = 2'd3
  } btn_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces one raw push-button: clean level, press/release/long-press strobes
// and a wrapping count of accepted presses.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter bit          ACTIVE_LOW        = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_in,
  output logic               btn_level,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_press,
  output logic [COUNT_W-1:0] press_count
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_PRESS_CYCLES);

  logic btn_pol;
  logic btn_s;

  // Polarity is normalised before synchronising so the sync reset value means "not pressed".
  assign btn_pol = ACTIVE_LOW ? ~btn_in : btn_in;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_pol),
    .q   (btn_s)
  );

  btn_state_e          state, state_nxt;
  logic [DB_W-1:0]     db_cnt, db_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt, hold_inc;
  logic [COUNT_W-1:0]  count_nxt;
  logic                level_nxt, press_nxt, release_nxt, long_nxt;

  // Saturating at LONG_PRESS_CYCLES keeps long_press from re-firing within one press.
  assign hold_inc = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + HOLD_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_RELEASED;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      press_count   <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_nxt;
      db_cnt        <= db_nxt;
      hold_cnt      <= hold_nxt;
      press_count   <= count_nxt;
      btn_level     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_press    <= long_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    db_nxt      = db_cnt;
    hold_nxt    = hold_cnt;
    count_nxt   = press_count;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;

    case (state)
      ST_RELEASED: begin
        if (btn_s) begin
          state_nxt = ST_DB_PRESS;
          db_nxt    = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!btn_s) begin
          state_nxt = ST_RELEASED;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = ST_PRESSED;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          count_nxt = press_count + COUNT_W'(1);
          hold_nxt  = '0;
        end else begin
          db_nxt = db_cnt + DB_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_nxt = ST_DB_RELEASE;
          db_nxt    = '0;
        end else begin
          hold_nxt = hold_inc;
          long_nxt = (hold_inc == HOLD_LAST);
        end
      end
      ST_DB_RELEASE: begin
        // Hold time keeps running so a release bounce does not restart the long-press timer.
        hold_nxt = hold_inc;
        if (btn_s) begin
          state_nxt = ST_PRESSED;
        end else if (db_cnt == DB_LAST) begin
          state_nxt   = ST_RELEASED;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          db_nxt = db_cnt + DB_W'(1);
        end
      end
      default: state_nxt = ST_RELEASED;
    endcase
  end

endmodule
